// File: rtl/zigzag_agu_if.sv
// Command/config and output-stream bundle of the zig-zag plane address generator.
// The master side issues jobs and consumes pairs; the slave side is the generator.
interface zigzag_agu_if #(
    parameter int BWADDR = 21,
    parameter int BPREC  = 4
);
    logic              clr;
    logic              start;
    logic [BPREC-1:0]  pw;
    logic [BPREC-1:0]  pd;
    logic              sgnw;
    logic              sgnd;
    logic [BWADDR-1:0] basew;
    logic [BWADDR-1:0] based;
    logic              busy;
    logic              err;
    logic              out_valid;
    logic              out_ready;
    logic [BPREC-1:0]  offw;
    logic [BPREC-1:0]  offd;
    logic [BWADDR-1:0] addrw;
    logic [BWADDR-1:0] addrd;
    logic [BPREC:0]    diag;
    logic              sh;
    logic              neg;
    logic              last;

    modport master (
        output clr, start, pw, pd, sgnw, sgnd, basew, based, out_ready,
        input  busy, err, out_valid, offw, offd, addrw, addrd, diag, sh, neg, last
    );

    modport slave (
        input  clr, start, pw, pd, sgnw, sgnd, basew, based, out_ready,
        output busy, err, out_valid, offw, offd, addrw, addrd, diag, sh, neg, last
    );
endinterface

// File: rtl/zigzag_agu.sv
// Zig-zag (anti-diagonal) walk over weight/data bit-plane pairs, one pair per handshake.
// First pair visible 1 cycle after start; outputs are registered and hold while out_ready is low.
module zigzag_agu #(
    parameter int BWADDR = 21,
    parameter int BPREC  = 4
) (
    input logic          clk,
    input logic          rst_n,
    zigzag_agu_if.slave  bus
);
    localparam int KW = BPREC + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     pw_q, pw_d, pd_q, pd_d;
    logic [KW-1:0]     iw_q, iw_d, id_q, id_d, k_q, k_d;
    logic              sgnw_q, sgnw_d, sgnd_q, sgnd_d;
    logic              err_q, err_d;
    logic [BWADDR-1:0] basew_q, basew_d, based_q, based_d;

    logic              run;
    logic              fire;
    logic              diag_end;
    logic              is_last;
    logic [KW-1:0]     k_nxt;
    logic [KW-1:0]     id_lo;

    assign run      = (state_q == RUN);
    assign fire     = run && bus.out_ready;
    assign k_nxt    = k_q + KW'(1);
    // Smallest data offset on the current diagonal; pairs at this offset open the diagonal.
    assign id_lo    = (k_q >= pw_q) ? (k_q - pw_q + KW'(1)) : '0;
    assign diag_end = (iw_q == '0) || (id_q == pd_q - KW'(1));
    assign is_last  = (k_q == pw_q + pd_q - KW'(2));

    always_comb begin
        state_d = state_q;
        pw_d    = pw_q;
        pd_d    = pd_q;
        sgnw_d  = sgnw_q;
        sgnd_d  = sgnd_q;
        basew_d = basew_q;
        based_d = based_q;
        iw_d    = iw_q;
        id_d    = id_q;
        k_d     = k_q;
        err_d   = 1'b0;

        if (bus.clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if ((bus.pw != '0) && (bus.pd != '0)) begin
                            state_d = RUN;
                            pw_d    = {1'b0, bus.pw};
                            pd_d    = {1'b0, bus.pd};
                            sgnw_d  = bus.sgnw;
                            sgnd_d  = bus.sgnd;
                            basew_d = bus.basew;
                            based_d = bus.based;
                            iw_d    = '0;
                            id_d    = '0;
                            k_d     = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fire) begin
                        if (is_last) begin
                            state_d = IDLE;
                        end else if (diag_end) begin
                            k_d = k_nxt;
                            if (k_nxt < pw_q) begin
                                iw_d = k_nxt;
                                id_d = '0;
                            end else begin
                                iw_d = pw_q - KW'(1);
                                id_d = k_nxt - pw_q + KW'(1);
                            end
                        end else begin
                            iw_d = iw_q - KW'(1);
                            id_d = id_q + KW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pw_q    <= '0;
            pd_q    <= '0;
            sgnw_q  <= 1'b0;
            sgnd_q  <= 1'b0;
            basew_q <= '0;
            based_q <= '0;
            iw_q    <= '0;
            id_q    <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pw_q    <= pw_d;
            pd_q    <= pd_d;
            sgnw_q  <= sgnw_d;
            sgnd_q  <= sgnd_d;
            basew_q <= basew_d;
            based_q <= based_d;
            iw_q    <= iw_d;
            id_q    <= id_d;
            k_q     <= k_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy      = run;
    assign bus.out_valid = run;
    assign bus.err       = err_q;
    assign bus.offw      = iw_q[BPREC-1:0];
    assign bus.offd      = id_q[BPREC-1:0];
    assign bus.addrw     = basew_q + {{(BWADDR-BPREC){1'b0}}, iw_q[BPREC-1:0]};
    assign bus.addrd     = based_q + {{(BWADDR-BPREC){1'b0}}, id_q[BPREC-1:0]};
    assign bus.diag      = k_q;
    assign bus.sh        = run && (id_q == id_lo) && (k_q != '0);
    assign bus.neg       = run && ((sgnw_q && (iw_q == pw_q - KW'(1))) ^
                                   (sgnd_q && (id_q == pd_q - KW'(1))));
    assign bus.last      = run && is_last;
endmodule

// File: tb/tb_zigzag_agu.sv
module tb_zigzag_agu;
    localparam int BWADDR = 21;
    localparam int BPREC  = 4;

    typedef struct packed {
        logic [3:0]  offw;
        logic [3:0]  offd;
        logic [20:0] addrw;
        logic [20:0] addrd;
        logic [4:0]  diag;
        logic        sh;
        logic        neg;
        logic        last;
    } pair_t;

    typedef struct {
        int pw;
        int pd;
        int sgnw;
        int sgnd;
        int basew;
        int based;
        int mode;     // 0: ready always high, 1: ready high every third cycle
        int wrap;
        int n;
        int nsh;
        int nneg;
    } job_t;

    logic clk;
    logic rst_n;

    zigzag_agu_if #(.BWADDR(BWADDR), .BPREC(BPREC)) bus ();

    zigzag_agu #(.BWADDR(BWADDR), .BPREC(BPREC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    pair_t exp_q[$];
    logic [3:0] obs_w[$];
    logic [3:0] obs_d[$];
    int    hs_cnt, sh_cnt, neg_cnt, last_cnt;
    int    chk_wrap = 0;
    bit    held = 0;
    pair_t held_p;
    pair_t last_p;
    job_t  jobs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic pair_t cur();
        pair_t p;
        p.offw  = bus.offw;
        p.offd  = bus.offd;
        p.addrw = bus.addrw;
        p.addrd = bus.addrd;
        p.diag  = bus.diag;
        p.sh    = bus.sh;
        p.neg   = bus.neg;
        p.last  = bus.last;
        return p;
    endfunction

    function automatic logic [63:0] all_outs();
        return {bus.busy, bus.err, bus.out_valid, bus.offw, bus.offd, bus.addrw,
                bus.addrd, bus.diag, bus.sh, bus.neg, bus.last};
    endfunction

    // Reference walk: enumerate each diagonal directly from its id range.
    task automatic push_model(input job_t j);
        pair_t p;
        int lo, hi, iw;
        for (int k = 0; k <= j.pw + j.pd - 2; k++) begin
            lo = (k - j.pw + 1 > 0) ? k - j.pw + 1 : 0;
            hi = (k < j.pd - 1) ? k : j.pd - 1;
            for (int id = lo; id <= hi; id++) begin
                iw      = k - id;
                p.offw  = 4'(iw);
                p.offd  = 4'(id);
                p.addrw = 21'(j.basew + iw);
                p.addrd = 21'(j.based + id);
                p.diag  = 5'(k);
                p.sh    = (id == lo) && (k != 0);
                p.neg   = ((j.sgnw != 0) && (iw == j.pw - 1)) ^ ((j.sgnd != 0) && (id == j.pd - 1));
                p.last  = (k == j.pw + j.pd - 2);
                exp_q.push_back(p);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (held) check("hold_stable", cur(), held_p);
            held = 0;
            if (bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pair: got (%0d,%0d), expected none", bus.offw, bus.offd);
                end else begin
                    check("pair", cur(), exp_q.pop_front());
                end
                obs_w.push_back(bus.offw);
                obs_d.push_back(bus.offd);
                hs_cnt++;
                sh_cnt   += int'(bus.sh);
                neg_cnt  += int'(bus.neg);
                last_cnt += int'(bus.last);
                if (bus.last) last_p = cur();
                if (chk_wrap != 0 && bus.offw == 4'd2) check("wrap_addrw", bus.addrw, 1);
            end else begin
                held   = 1;
                held_p = cur();
            end
        end else begin
            held = 0;
        end
    end

    task automatic drive_start(input job_t j);
        bus.pw    = 4'(j.pw);
        bus.pd    = 4'(j.pd);
        bus.sgnw  = (j.sgnw != 0);
        bus.sgnd  = (j.sgnd != 0);
        bus.basew = 21'(j.basew);
        bus.based = 21'(j.based);
        bus.start = 1'b1;
    endtask

    task automatic run_job(input job_t j, input bit keep_start);
        int cyc;
        hs_cnt = 0; sh_cnt = 0; neg_cnt = 0; last_cnt = 0;
        obs_w.delete();
        obs_d.delete();
        chk_wrap = j.wrap;
        push_model(j);
        @(posedge clk); #1;
        drive_start(j);
        @(posedge clk); #1;
        bus.start = keep_start;
        if (keep_start) begin
            bus.pw = 4'd2;
            bus.pd = 4'd2;
        end
        check("start_latency", {bus.busy, bus.out_valid, bus.offw, bus.offd}, {2'b11, 8'h00});
        cyc = 0;
        while (bus.out_valid && cyc < 2000) begin
            bus.out_ready = (j.mode == 0) || (cyc % 3 == 0);
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        if (cyc >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL job_timeout: got %0d cycles, expected completion", cyc);
        end
        check("pair_count", hs_cnt, j.n);
        check("sh_count", sh_cnt, j.nsh);
        check("neg_count", neg_cnt, j.nneg);
        check("last_count", last_cnt, 1);
        check("scoreboard_empty", exp_q.size(), 0);
        check("busy_after_last", {bus.busy, bus.out_valid}, 0);
        if (j.mode == 0) check("job_cycles", cyc, j.pw * j.pd);
        chk_wrap = 0;
    endtask

    initial begin
        int ew[6];
        int ed[6];
        ew = '{0, 1, 0, 2, 1, 0};
        ed = '{0, 0, 1, 0, 1, 2};

        //          pw pd sw sd basew       based       md wr  n nsh nneg
        jobs[0] = '{6, 4, 0, 0, 100,        200,        0, 0, 24, 8, 0};
        jobs[1] = '{4, 6, 1, 1, 0,          4096,       0, 0, 24, 8, 8};
        jobs[2] = '{3, 3, 0, 0, 16,         32,         1, 0,  9, 4, 0};
        jobs[3] = '{3, 2, 1, 0, 2097151,    2097150,    0, 1,  6, 3, 2};
        jobs[4] = '{1, 1, 0, 0, 5,          9,          0, 0,  1, 0, 0};
        jobs[5] = '{5, 1, 1, 1, 1000,       77,         1, 0,  5, 4, 4};

        rst_n = 1'b0;
        bus.clr = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b1;
        bus.pw = '0; bus.pd = '0; bus.sgnw = 1'b0; bus.sgnd = 1'b0;
        bus.basew = '0; bus.based = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_job(jobs[i], 1'b0);
            if (i == 0) begin
                for (int m = 0; m < 6; m++)
                    check($sformatf("order_%0d", m), {obs_w[m], obs_d[m]}, {4'(ew[m]), 4'(ed[m])});
                check("diag6_a", {obs_w[18], obs_d[18]}, {4'd5, 4'd1});
                check("diag6_b", {obs_w[19], obs_d[19]}, {4'd4, 4'd2});
                check("diag6_c", {obs_w[20], obs_d[20]}, {4'd3, 4'd3});
                check("last_pair_6x4", {last_p.offw, last_p.offd}, {4'd5, 4'd3});
            end
            if (i == 1) check("last_pair_4x6", {last_p.offw, last_p.offd, last_p.neg}, {4'd3, 4'd5, 1'b0});
        end

        // Zero precision is rejected with a single-cycle err pulse.
        @(posedge clk); #1;
        bus.pw = 4'd0; bus.pd = 4'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("err_pulse_pw0", {bus.err, bus.busy, bus.out_valid}, 3'b100);
        @(posedge clk); #1;
        check("err_clears", {bus.err, bus.busy}, 0);
        bus.pw = 4'd2; bus.pd = 4'd0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("err_pulse_pd0", {bus.err, bus.busy}, 2'b10);

        // start held high through a whole job, including its final cycle, is ignored.
        run_job('{3, 3, 0, 0, 7, 11, 0, 0, 9, 4, 0}, 1'b1);
        @(posedge clk); #1;
        check("idle_after_held_start", bus.busy, 0);

        // clr while pair 5 is on the output.
        obs_w.delete(); obs_d.delete();
        push_model(jobs[0]);
        @(posedge clk); #1;
        drive_start(jobs[0]);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("pair5_before_clr", {bus.offw, bus.offd}, {4'd0, 4'd2});
        bus.out_ready = 1'b0;
        bus.clr = 1'b1;
        @(posedge clk); #1;
        bus.clr = 1'b0;
        check("clr_outputs", {bus.out_valid, bus.busy, bus.sh, bus.last}, 0);
        exp_q.delete();
        run_job('{2, 2, 0, 0, 40, 50, 0, 0, 4, 2, 0}, 1'b0);
        check("restart_first_pair", {obs_w[0], obs_d[0]}, 0);

        // Asynchronous reset in the middle of a cycle.
        push_model(jobs[1]);
        @(posedge clk); #1;
        drive_start(jobs[1]);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", all_outs(), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", {bus.busy, bus.out_valid}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end
endmodule

// File: doc/zigzag_agu.md
# zigzag_agu

Parametrised zig-zag address generator for the bit-serial MVU datapath. Given weight and data precisions, it walks every (weight-bit, data-bit) plane pair in anti-diagonal order, from least to most significant. It emits plane addresses, a shift strobe for the shift-accumulator and a sign flag for two's-complement MSB planes. Output is under valid/ready backpressure with per-job start/last framing.

## Interface
- BWADDR, 21: bitwidth of plane addresses
- BPREC, 4: bitwidth of precision specifiers and plane offsets

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous abort; overrides all other inputs
- start  in  1  job request; sampled only in IDLE
- pw  in  BPREC  weight precision, sampled at accepted start
- pd  in  BPREC  data precision, sampled at accepted start
- sgnw  in  1  weights are two's complement, sampled at accepted start
- sgnd  in  1  data is two's complement, sampled at accepted start
- basew  in  BWADDR  weight plane base address, sampled at accepted start
- based  in  BWADDR  data plane base address, sampled at accepted start
- busy  out  1  job in progress
- err  out  1  one-cycle pulse: start rejected because pw==0 or pd==0
- out_valid  out  1  output pair valid
- out_ready  in  1  consumer accepts pair
- offw  out  BPREC  weight plane offset iw
- offd  out  BPREC  data plane offset id
- addrw  out  BWADDR  basew + offw, mod 2^BWADDR
- addrd  out  BWADDR  based + offd, mod 2^BWADDR
- diag  out  BPREC+1  diagonal index k = iw+id (plane significance)
- sh  out  1  pair is first of diagonal k>0; accumulator shifts before adding
- neg  out  1  product plane negative
- last  out  1  final pair of job

## Operation
- States: IDLE, RUN.
- IDLE:
  - start && pw!=0 && pd!=0: latch config, load (iw,id)=(0,0), go to RUN.
  - start with a zero precision: stay in IDLE, pulse err.
- RUN: out_valid=1. Output fields come from registers. The pair advances only on handshake (out_valid && out_ready).
- Walk order: for k = 0 .. pw+pd-2, visit id = max(0, k-pw+1) .. min(k, pd-1) ascending, with iw = k-id. Total pw*pd pairs, each exactly once.
- Advance within a diagonal: id+1, iw-1.
- Diagonal end: iw==0 or id==pd-1.
  - Next k' = k+1.
  - If k' < pw: iw=k', id=0.
  - Else: iw=pw-1, id=k'-pw+1.
- sh = (id == max(0, k-pw+1)) && k != 0.
- neg = (sgnw && iw==pw-1) XOR (sgnd && id==pd-1).
- last = (k == pw+pd-2). The final diagonal holds exactly one pair.
- Handshake on last pair: go to IDLE, out_valid=0.
- start is ignored while in RUN.
- Internal k/iw/id arithmetic is BPREC+1 bits wide, so pw+pd-2 never overflows.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE. All outputs 0: busy, err, out_valid, offw, offd, addrw, addrd, diag, sh, neg, last.
- Start accepted at edge N: busy=1 and out_valid=1 with pair (0,0) visible after edge N. Latency is 1 cycle.
- Throughput: one pair per cycle while out_ready=1. A job takes pw*pd cycles under no backpressure.
- out_ready low: all outputs hold stable, no advance.
- After the last handshake at edge M: busy=0, out_valid=0.
  - The earliest next start is sampled at edge M+1.
  - A start asserted during the cycle ending at edge M is ignored.
- clr at an edge: state=IDLE, out_valid=0, busy=0, sh=0, last=0. Takes priority over start and handshake in the same cycle.
- err: high for exactly the one cycle after the rejected start edge.
- pw=pd=1: a single pair (0,0) with last=1 and sh=0.

## Test plan
- pw=6, pd=4, out_ready=1:
  - 24 pairs in 24 consecutive cycles; diag runs 0..8; sh high on 8 pairs (first of k=1..8).
  - Sequence begins (0,0),(1,0),(0,1),(2,0),(1,1),(0,2).
  - Diagonal k=6 is (5,1),(4,2),(3,3).
  - last on (5,3) only.
- pw=4, pd=6, sgnw=sgnd=1:
  - neg high exactly on pairs with iw==3 xor id==5.
  - Pair (3,5) has neg=0 and last=1.
- Backpressure: pw=3, pd=3, out_ready toggling 1,0,0,1…; every pair is held stable while ready is low; 9 unique pairs, none dropped or duplicated.
- Wrap: basew=2^21-1, offw=2 -> addrw=1. pw=1, pd=1 -> one pair, last=1, busy low the next cycle.
- Abort and reset:
  - clr mid-job (pair 5 of 24) -> out_valid=0 next cycle; a fresh start restarts at (0,0).
  - rst_n low mid-cycle -> outputs 0 immediately, without waiting for a clock edge.
- start with pw=0 -> err pulses one cycle, busy stays 0. start while busy -> ignored; the running sequence is unaltered.
